data_region_addr_gen: RTL and testbench
=======================================

// Module: data_region_addr_gen
// PURPOSE
//  Maps CPU data-memory offsets into a parametrised data region, with modulo wrap-around.
//  Also owns the hardware stack pointer for a downward-growing stack region, serving PUSH/POP address requests.
//  Sits between the decode/execute stage and the data-memory port; one registered output per accepted request.
// PARAMETERS
//  ADDR_W      8    address width (offset, SP and output address)
//  DATA_BASE   128  first byte of the data region
//  DATA_SIZE   96   data region bytes; region = [DATA_BASE, DATA_BASE+DATA_SIZE-1]
//  STACK_BASE  224  lowest byte of the stack region
//  STACK_SIZE  32   stack region bytes; region = [STACK_BASE, STACK_BASE+STACK_SIZE-1]
// PORTS
//  clk        in   1       single clock, all state on posedge
//  rst        in   1       synchronous reset, active-high
//  in_valid   in   1       request valid
//  in_ready   out  1       request accepted when in_valid && in_ready
//  mode       in   2       00 DIRECT, 01 PUSH, 10 POP, 11 SP_LOAD
//  addr_in    in   ADDR_W  DIRECT: offset; SP_LOAD: new SP; ignored for PUSH/POP
//  out_valid  out  1       addr_out valid
//  out_ready  in   1       consumer accepts addr_out
//  addr_out   out  ADDR_W  generated physical address
//  sp         out  ADDR_W  current stack pointer (next free slot)
//  depth      out  $clog2(STACK_SIZE+1)  occupied stack bytes
//  err_ovf    out  1       1-cycle pulse: PUSH refused, stack full
//  err_unf    out  1       1-cycle pulse: POP refused, stack empty
//  err_range  out  1       1-cycle pulse: SP_LOAD value outside stack region
// BEHAVIOUR
//  Reset (rst=1 at posedge): out_valid=0, addr_out=DATA_BASE, sp=STACK_BASE+STACK_SIZE-1, depth=0, all err_*=0.
//    Reset overrides everything, including an accepted request or a stalled output; pending output is discarded.
//  Handshake:
//    in_ready = !out_valid || out_ready (combinational).
//    Single output register; latency 1 cycle, accept at edge N gives out_valid at N+1.
//    Back-to-back throughput 1/cycle while out_ready=1.
//    While out_valid && !out_ready: addr_out and out_valid held stable, no request accepted.
//  DIRECT: addr_out = DATA_BASE + (addr_in mod DATA_SIZE).
//    The mod is constant-modulus, full ADDR_W input range, result never outside the data region.
//    Example: offset 95 gives 223; offset 96 gives 128; offset 255 gives 191.
//  PUSH: if depth<STACK_SIZE, addr_out=sp, then sp<=sp-1, depth+1.
//    Else no output (out_valid stays 0), err_ovf pulses, sp/depth unchanged.
//  POP: if depth>0, sp<=sp+1, addr_out=sp+1 (pre-increment), depth-1.
//    Else no output, err_unf pulses, state unchanged.
//  SP_LOAD: if STACK_BASE-1 <= addr_in <= STACK_BASE+STACK_SIZE-1:
//    sp<=addr_in, depth<=STACK_BASE+STACK_SIZE-1-addr_in.
//    No addr_out produced (out_valid=0 next cycle).
//    Else err_range pulses, state unchanged.
//  SP/depth update on the acceptance edge, so a following request sees the new sp.
//  err_* pulses are asserted the cycle after the refused request is accepted; they are never sticky.
//  All arithmetic is ADDR_W wide, computed with one extra bit internally; no silent ADDR_W truncation reaches addr_out.
//  Elaboration check: $error if either region exceeds 2**ADDR_W, or if the two regions overlap.
// STRUCTURE
//  Shared package dag_pkg: mode localparams MODE_DIRECT/MODE_PUSH/MODE_POP/MODE_SP_LOAD (2-bit).
//  Sub-module stack_ptr_unit: sp/depth registers, full/empty, PUSH/POP/LOAD next-state, ovf/unf/range detect.
//  Top level: DIRECT mapper, output register, handshake.
// TESTING
//  1 DIRECT sweep offsets 0,95,96,191,255 with out_ready=1 -> addr_out 128,223,128,223,191, one per cycle.
//  2 Push 32x from reset -> addr_out 255..224. Then 33rd PUSH -> err_ovf=1 one cycle, no out_valid, sp=223, depth=32.
//  3 POP 32x -> addr_out 224..255. Then POP -> err_unf pulse, sp=255, depth=0.
//  4 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, addr_out stable. Release -> queued request emerges next cycle.
//  5 SP_LOAD 240 -> sp=240, depth=15; SP_LOAD 100 -> err_range, sp stays 240.
//  6 rst=1 during stalled output with depth=5 -> next cycle out_valid=0, sp=255, depth=0.

Source files
------------

// File: rtl/data_region_addr_gen_pkg.sv
// ---------------------------------------------------------------------------
// dag_pkg
//   Shared definitions for the data-region / stack address generator.
//   mode_e : request opcode carried on the request bus
//            MODE_DIRECT  - offset into the data region (modulo wrap)
//            MODE_PUSH    - stack push address (post-decrement SP)
//            MODE_POP     - stack pop address (pre-increment SP)
//            MODE_SP_LOAD - load a new stack pointer, no address produced
// ---------------------------------------------------------------------------
package dag_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT  = 2'b00,
        MODE_PUSH    = 2'b01,
        MODE_POP     = 2'b10,
        MODE_SP_LOAD = 2'b11
    } mode_e;

endpackage

// File: rtl/data_region_addr_gen_if.sv
// ---------------------------------------------------------------------------
// data_region_addr_gen_if
//   Request/response bus of the address generator.
//   Request side  : in_valid, in_ready, mode, addr_in
//   Response side : out_valid, out_ready, addr_out
//   Status        : sp, depth, err_ovf, err_unf, err_range
//   master : the requester/consumer (drives requests, accepts addresses)
//   slave  : the address generator
// ---------------------------------------------------------------------------
interface data_region_addr_gen_if
    import dag_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DEPTH_W = 6
);

    logic               in_valid;
    logic               in_ready;
    mode_e              mode;
    logic [ADDR_W-1:0]  addr_in;
    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  addr_out;
    logic [ADDR_W-1:0]  sp;
    logic [DEPTH_W-1:0] depth;
    logic               err_ovf;
    logic               err_unf;
    logic               err_range;

    modport master (
        output in_valid, mode, addr_in, out_ready,
        input  in_ready, out_valid, addr_out, sp, depth,
               err_ovf, err_unf, err_range
    );

    modport slave (
        input  in_valid, mode, addr_in, out_ready,
        output in_ready, out_valid, addr_out, sp, depth,
               err_ovf, err_unf, err_range
    );

endinterface

// File: rtl/data_region_addr_gen_stack_ptr_unit.sv
// ---------------------------------------------------------------------------
// stack_ptr_unit
//   Owns the downward-growing stack pointer and occupancy counter.
//   clk, rst      : clock, synchronous active-high reset
//   i_push/i_pop/i_load : accepted request of that kind (mutually exclusive)
//   i_load_val    : new SP value for a load
//   o_sp, o_depth : current SP (next free slot) and occupied bytes
//   o_full/o_empty: combinational occupancy flags for the current state
//   o_err_*       : one-cycle pulses for refused push / pop / out-of-range load
// ---------------------------------------------------------------------------
module stack_ptr_unit #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned STACK_BASE = 224,
    parameter int unsigned STACK_SIZE = 32,
    parameter int unsigned DEPTH_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_load,
    input  logic [ADDR_W-1:0]  i_load_val,
    output logic [ADDR_W-1:0]  o_sp,
    output logic [DEPTH_W-1:0] o_depth,
    output logic               o_full,
    output logic               o_empty,
    output logic               o_err_ovf,
    output logic               o_err_unf,
    output logic               o_err_range
);

    localparam int unsigned       STACK_TOP = STACK_BASE + STACK_SIZE - 1;
    localparam logic [ADDR_W:0]   C_TOP_X   = (ADDR_W+1)'(STACK_TOP);
    localparam logic [ADDR_W:0]   C_BASE_X  = (ADDR_W+1)'(STACK_BASE);
    localparam logic [DEPTH_W-1:0] C_SIZE   = DEPTH_W'(STACK_SIZE);

    logic [ADDR_W-1:0]  r_sp;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_err_ovf;
    logic               r_err_unf;
    logic               r_err_range;

    logic [ADDR_W:0]    w_load_x;
    logic               w_load_ok;
    logic [DEPTH_W-1:0] w_load_depth;

    assign o_full  = (r_depth == C_SIZE);
    assign o_empty = (r_depth == '0);

    // STACK_BASE-1 is a legal load (empty-below-base = full stack), so the
    // lower bound is checked as val+1 >= base in the widened domain.
    assign w_load_x     = {1'b0, i_load_val};
    assign w_load_ok    = ((w_load_x + (ADDR_W+1)'(1)) >= C_BASE_X) && (w_load_x <= C_TOP_X);
    assign w_load_depth = DEPTH_W'(C_TOP_X - w_load_x);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp        <= ADDR_W'(STACK_TOP);
            r_depth     <= '0;
            r_err_ovf   <= 1'b0;
            r_err_unf   <= 1'b0;
            r_err_range <= 1'b0;
        end else begin
            r_err_ovf   <= 1'b0;
            r_err_unf   <= 1'b0;
            r_err_range <= 1'b0;
            if (i_push) begin
                if (!o_full) begin
                    r_sp    <= r_sp - ADDR_W'(1);
                    r_depth <= r_depth + DEPTH_W'(1);
                end else begin
                    r_err_ovf <= 1'b1;
                end
            end else if (i_pop) begin
                if (!o_empty) begin
                    r_sp    <= r_sp + ADDR_W'(1);
                    r_depth <= r_depth - DEPTH_W'(1);
                end else begin
                    r_err_unf <= 1'b1;
                end
            end else if (i_load) begin
                if (w_load_ok) begin
                    r_sp    <= i_load_val;
                    r_depth <= w_load_depth;
                end else begin
                    r_err_range <= 1'b1;
                end
            end
        end
    end

    assign o_sp        = r_sp;
    assign o_depth     = r_depth;
    assign o_err_ovf   = r_err_ovf;
    assign o_err_unf   = r_err_unf;
    assign o_err_range = r_err_range;

endmodule

// File: rtl/data_region_addr_gen.sv
// ---------------------------------------------------------------------------
// data_region_addr_gen
//   Maps data-memory offsets into [DATA_BASE, DATA_BASE+DATA_SIZE-1] with
//   modulo wrap, and serves PUSH/POP/SP_LOAD requests against a downward
//   growing stack. One registered address per accepted request, latency 1.
//   clk : clock (posedge)
//   rst : synchronous active-high reset
//   bus : request/response/status interface (slave side)
// ---------------------------------------------------------------------------
module data_region_addr_gen
    import dag_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_BASE  = 128,
    parameter int unsigned DATA_SIZE  = 96,
    parameter int unsigned STACK_BASE = 224,
    parameter int unsigned STACK_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    data_region_addr_gen_if.slave bus
);

    localparam int unsigned DEPTH_W    = $clog2(STACK_SIZE + 1);
    localparam longint      ADDR_SPACE = longint'(1) << ADDR_W;

    if (DATA_SIZE == 0 || longint'(DATA_BASE) + longint'(DATA_SIZE) > ADDR_SPACE) begin : g_bad_data
        $error("data region does not fit in the address space");
    end
    if (STACK_SIZE == 0 || longint'(STACK_BASE) + longint'(STACK_SIZE) > ADDR_SPACE) begin : g_bad_stack
        $error("stack region does not fit in the address space");
    end
    if (DATA_BASE < STACK_BASE + STACK_SIZE && STACK_BASE < DATA_BASE + DATA_SIZE) begin : g_overlap
        $error("data and stack regions overlap");
    end

    localparam logic [ADDR_W:0] C_DSIZE_X = (ADDR_W+1)'(DATA_SIZE);
    localparam logic [ADDR_W:0] C_DBASE_X = (ADDR_W+1)'(DATA_BASE);

    logic               r_out_valid;
    logic [ADDR_W-1:0]  r_addr;

    logic               w_accept;
    logic [ADDR_W:0]    w_mod;
    logic [ADDR_W-1:0]  w_direct_addr;
    logic [ADDR_W-1:0]  w_sp;
    logic [ADDR_W-1:0]  w_sp_inc;
    logic [DEPTH_W-1:0] w_depth;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_load;
    logic               w_emit;
    logic [ADDR_W-1:0]  w_emit_addr;

    assign bus.in_ready = !r_out_valid || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready;

    // Region checks above guarantee base + (offset mod size) and sp + 1 of a
    // non-empty stack fit in ADDR_W, so narrowing the widened sums is exact.
    assign w_mod         = {1'b0, bus.addr_in} % C_DSIZE_X;
    assign w_direct_addr = ADDR_W'(w_mod + C_DBASE_X);
    assign w_sp_inc      = ADDR_W'({1'b0, w_sp} + (ADDR_W+1)'(1));

    always_comb begin
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_emit      = 1'b0;
        w_emit_addr = w_direct_addr;
        if (w_accept) begin
            case (bus.mode)
                MODE_DIRECT: begin
                    w_emit = 1'b1;
                end
                MODE_PUSH: begin
                    w_push      = 1'b1;
                    w_emit      = !w_full;
                    w_emit_addr = w_sp;
                end
                MODE_POP: begin
                    w_pop       = 1'b1;
                    w_emit      = !w_empty;
                    w_emit_addr = w_sp_inc;
                end
                MODE_SP_LOAD: begin
                    w_load = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A refused or SP_LOAD request still consumes the slot: out_valid drops,
    // addr_out keeps its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_addr      <= ADDR_W'(DATA_BASE);
        end else if (w_accept) begin
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_addr <= w_emit_addr;
            end
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    stack_ptr_unit #(
        .ADDR_W     (ADDR_W),
        .STACK_BASE (STACK_BASE),
        .STACK_SIZE (STACK_SIZE),
        .DEPTH_W    (DEPTH_W)
    ) u_stack (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_load      (w_load),
        .i_load_val  (bus.addr_in),
        .o_sp        (w_sp),
        .o_depth     (w_depth),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_err_ovf   (bus.err_ovf),
        .o_err_unf   (bus.err_unf),
        .o_err_range (bus.err_range)
    );

    assign bus.out_valid = r_out_valid;
    assign bus.addr_out  = r_addr;
    assign bus.sp        = w_sp;
    assign bus.depth     = w_depth;

endmodule

// File: tb/tb_data_region_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_data_region_addr_gen
//   Directed bench for data_region_addr_gen with default parameters
//   (data region 128..223, stack region 224..255).
// ---------------------------------------------------------------------------
module tb_data_region_addr_gen;
    import dag_pkg::*;

    typedef struct {
        mode_e      mode;
        logic [7:0] addr;
        logic       exp_valid;
        logic [7:0] exp_addr;
        logic [7:0] exp_sp;
        logic [5:0] exp_depth;
        logic [2:0] exp_err;     // {ovf, unf, range}
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_run  = 0;
    int unsigned n_fail = 0;
    vec_t vecs[$];

    data_region_addr_gen_if #(.ADDR_W(8), .DEPTH_W(6)) bus ();

    data_region_addr_gen #(
        .ADDR_W     (8),
        .DATA_BASE  (128),
        .DATA_SIZE  (96),
        .STACK_BASE (224),
        .STACK_SIZE (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: act=%0d req=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input mode_e m, input logic [7:0] a);
        bus.in_valid = 1'b1;
        bus.mode     = m;
        bus.addr_in  = a;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.mode     = MODE_DIRECT;
        bus.addr_in  = 8'd0;
    endtask

    task automatic do_reset();
        idle();
        bus.out_ready = 1'b1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic add(input mode_e m, input int unsigned a, input bit v, input int unsigned ea,
                       input int unsigned esp, input int unsigned ed, input logic [2:0] ee);
        vec_t t;
        t.mode = m; t.addr = 8'(a); t.exp_valid = v; t.exp_addr = 8'(ea);
        t.exp_sp = 8'(esp); t.exp_depth = 6'(ed); t.exp_err = ee;
        vecs.push_back(t);
    endtask

    initial begin
        // Table continues from reset state: sp=255, depth=0.
        add(MODE_DIRECT,    0, 1, 128, 255,  0, 3'b000);
        add(MODE_DIRECT,   95, 1, 223, 255,  0, 3'b000);
        add(MODE_DIRECT,   96, 1, 128, 255,  0, 3'b000);
        add(MODE_DIRECT,  191, 1, 223, 255,  0, 3'b000);
        add(MODE_DIRECT,  255, 1, 191, 255,  0, 3'b000);
        add(MODE_POP,       0, 0,   0, 255,  0, 3'b010);
        add(MODE_SP_LOAD, 240, 0,   0, 240, 15, 3'b000);
        add(MODE_SP_LOAD, 100, 0,   0, 240, 15, 3'b001);
        add(MODE_SP_LOAD, 223, 0,   0, 223, 32, 3'b000);
        add(MODE_PUSH,      0, 0,   0, 223, 32, 3'b100);
        add(MODE_SP_LOAD, 222, 0,   0, 223, 32, 3'b001);
        add(MODE_SP_LOAD, 224, 0,   0, 224, 31, 3'b000);
        add(MODE_PUSH,      0, 1, 224, 223, 32, 3'b000);
        add(MODE_POP,       0, 1, 224, 224, 31, 3'b000);
        add(MODE_SP_LOAD, 255, 0,   0, 255,  0, 3'b000);
        add(MODE_PUSH,      0, 1, 255, 254,  1, 3'b000);
        add(MODE_DIRECT,  127, 1, 159, 254,  1, 3'b000);
        add(MODE_SP_LOAD,   0, 0,   0, 254,  1, 3'b001);

        // Reset state
        do_reset();
        chk("rst.out_valid", bus.out_valid, 0);
        chk("rst.addr_out",  bus.addr_out, 128);
        chk("rst.sp",        bus.sp, 255);
        chk("rst.depth",     bus.depth, 0);
        chk("rst.err",       {bus.err_ovf, bus.err_unf, bus.err_range}, 0);
        chk("rst.in_ready",  bus.in_ready, 1);

        // Table-driven vectors, back to back
        foreach (vecs[i]) begin
            drive(vecs[i].mode, vecs[i].addr);
            step();
            chk($sformatf("vec%0d.valid", i), bus.out_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid)
                chk($sformatf("vec%0d.addr", i), bus.addr_out, vecs[i].exp_addr);
            chk($sformatf("vec%0d.sp", i),    bus.sp, vecs[i].exp_sp);
            chk($sformatf("vec%0d.depth", i), bus.depth, vecs[i].exp_depth);
            chk($sformatf("vec%0d.err", i),   {bus.err_ovf, bus.err_unf, bus.err_range}, vecs[i].exp_err);
        end
        idle();
        step();
        chk("tbl.err_clear", {bus.err_ovf, bus.err_unf, bus.err_range}, 0);

        // Fill the stack from reset, then overflow
        do_reset();
        for (int i = 0; i < 32; i++) begin
            drive(MODE_PUSH, 8'd0);
            step();
            chk($sformatf("push%0d.valid", i), bus.out_valid, 1);
            chk($sformatf("push%0d.addr", i),  bus.addr_out, 255 - i);
        end
        step();
        chk("ovf.err_ovf",   bus.err_ovf, 1);
        chk("ovf.out_valid", bus.out_valid, 0);
        chk("ovf.sp",        bus.sp, 223);
        chk("ovf.depth",     bus.depth, 32);
        idle();
        step();
        chk("ovf.pulse_end", bus.err_ovf, 0);

        // Drain the stack, then underflow
        for (int i = 0; i < 32; i++) begin
            drive(MODE_POP, 8'd0);
            step();
            chk($sformatf("pop%0d.valid", i), bus.out_valid, 1);
            chk($sformatf("pop%0d.addr", i),  bus.addr_out, 224 + i);
        end
        step();
        chk("unf.err_unf",   bus.err_unf, 1);
        chk("unf.out_valid", bus.out_valid, 0);
        chk("unf.sp",        bus.sp, 255);
        chk("unf.depth",     bus.depth, 0);
        idle();
        step();
        chk("unf.pulse_end", bus.err_unf, 0);

        // Output stall: held output, request queued until release
        drive(MODE_DIRECT, 8'd10);
        step();
        chk("stall.first_valid", bus.out_valid, 1);
        chk("stall.first_addr",  bus.addr_out, 138);
        bus.out_ready = 1'b0;
        drive(MODE_DIRECT, 8'd20);
        #1;
        chk("stall.in_ready0", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall%0d.in_ready", i), bus.in_ready, 0);
            chk($sformatf("stall%0d.valid", i),    bus.out_valid, 1);
            chk($sformatf("stall%0d.addr", i),     bus.addr_out, 138);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("stall.release_ready", bus.in_ready, 1);
        step();
        chk("stall.queued_valid", bus.out_valid, 1);
        chk("stall.queued_addr",  bus.addr_out, 148);
        idle();
        step();
        chk("stall.drain_valid", bus.out_valid, 0);

        // Reset during a stalled output with depth 5
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(MODE_PUSH, 8'd0);
            step();
        end
        chk("rstst.addr",  bus.addr_out, 251);
        chk("rstst.depth", bus.depth, 5);
        bus.out_ready = 1'b0;
        step();
        chk("rstst.held_valid", bus.out_valid, 1);
        chk("rstst.held_depth", bus.depth, 5);
        rst = 1'b1;
        step();
        chk("rstst.out_valid", bus.out_valid, 0);
        chk("rstst.sp",        bus.sp, 255);
        chk("rstst.depth",     bus.depth, 0);
        chk("rstst.addr_out",  bus.addr_out, 128);
        rst = 1'b0;
        idle();
        bus.out_ready = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
